shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_pkg.sv | 26 ++
 rtl/shifter_core.sv | 30 +++
 rtl/shift_arbiter.sv | 119 +++++++++++
 tb/tb_shift_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift arbiter and its shifter datapath.
// SHIFT_ARBITER_SRA_EN selects whether opcode 2'b10 is an arithmetic right shift or illegal.
package shift_pkg;

    localparam int unsigned SHIFT_N = 32;

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_SRA  = 2'b10,
        SHIFT_RSVD = 2'b11
    } shift_op_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

    // Result slot contents, registered as one unit so they always change together.
    typedef struct packed {
        logic [SHIFT_N-1:0] data;
        logic               id;
        logic               err;
    } rsp_t;

endpackage

// File: rtl/shifter_core.sv
// Combinational shift datapath shared by both requesters.
// Arithmetic right shift exists only when SHIFT_ARBITER_SRA_EN is defined.
module shifter_core
    import shift_pkg::*;
#(
    parameter int unsigned N   = SHIFT_N,
    parameter int unsigned SHW = $clog2(N)
) (
    input  logic [N-1:0]   in_i,
    input  logic [SHW-1:0] shamt_i,
    input  shift_op_t      op_i,
    output logic [N-1:0]   out_o,
    output logic           err_o
);

    always_comb begin
        out_o = '0;
        err_o = 1'b0;
        unique case (op_i)
            SHIFT_SLL: out_o = in_i << shamt_i;
            SHIFT_SRL: out_o = in_i >> shamt_i;
`ifdef SHIFT_ARBITER_SRA_EN
            SHIFT_SRA: out_o = N'($signed(in_i) >>> shamt_i);
`endif
            // Illegal opcodes still complete, but yield zero with the error flag set.
            default:   err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of one shifter, with a single registered result slot.
// Build option SHIFT_ARBITER_SRA_EN enables arithmetic right shift in the shared core.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int unsigned N   = SHIFT_N,
    parameter int unsigned SHW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [1:0]     req0_op,
    input  logic [N-1:0]   req0_in,
    input  logic [SHW-1:0] req0_shamt,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [1:0]     req1_op,
    input  logic [N-1:0]   req1_in,
    input  logic [SHW-1:0] req1_shamt,

    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [N-1:0]   rsp_data,
    output logic           rsp_id,
    output logic           rsp_err
);

    arb_state_t     state_q, state_d;
    logic           prio_q, prio_d;
    logic [N-1:0]   data_q, data_d;
    logic           id_q, id_d;
    logic           err_q, err_d;

    logic           slot_free;
    logic           grant0, grant1, grant_any;
    logic [N-1:0]   sel_in;
    logic [SHW-1:0] sel_shamt;
    shift_op_t      sel_op;
    logic [N-1:0]   core_out;
    logic           core_err;

    // Readys look only at the other requester's valid, never their own.
    always_comb begin
        slot_free  = (state_q == EMPTY) || rsp_ready;
        req0_ready = !rst && slot_free && (!prio_q || !req1_valid);
        req1_ready = !rst && slot_free && ( prio_q || !req0_valid);
        grant0     = req0_valid && req0_ready;
        grant1     = req1_valid && req1_ready;
        grant_any  = grant0 || grant1;
    end

    always_comb begin
        sel_in    = grant1 ? req1_in    : req0_in;
        sel_shamt = grant1 ? req1_shamt : req0_shamt;
        sel_op    = shift_op_t'(grant1 ? req1_op : req0_op);
    end

    shifter_core #(
        .N   (N),
        .SHW (SHW)
    ) u_shifter_core (
        .in_i    (sel_in),
        .shamt_i (sel_shamt),
        .op_i    (sel_op),
        .out_o   (core_out),
        .err_o   (core_err)
    );

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        data_d  = data_q;
        id_d    = id_q;
        err_d   = err_q;
        if (grant_any) begin
            // A new transfer refills the slot even while the old result drains.
            state_d = FULL;
            data_d  = core_out;
            id_d    = grant1;
            err_d   = core_err;
            prio_d  = ~grant1;
        end else if ((state_q == FULL) && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            prio_q  <= 1'b0;
            data_q  <= '0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            data_q  <= data_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        rsp_valid = (state_q == FULL);
        rsp_data  = data_q;
        rsp_id    = id_q;
        rsp_err   = err_q;
    end

    a_single_grant: assert property (@(posedge clk) !(grant0 && grant1));

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (rsp_valid && !rsp_ready) |=>
        (rsp_valid && $stable(rsp_data) && $stable(rsp_id) && $stable(rsp_err)));

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus randomized traffic
// against an arithmetic reference model.
module tb_shift_arbiter;
    import shift_pkg::*;

    localparam int N   = 32;
    localparam int SHW = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]     req0_op, req1_op;
    logic [N-1:0]   req0_in, req1_in;
    logic [SHW-1:0] req0_shamt, req1_shamt;
    logic           rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [N-1:0]   rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_full, m_id, m_err, m_prio;
    logic [31:0] m_data;
    bit          last_g0, last_g1;

    always #5 clk = ~clk;

    shift_arbiter #(
        .N   (N),
        .SHW (SHW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_in    (req0_in),
        .req0_shamt (req0_shamt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_in    (req1_in),
        .req1_shamt (req1_shamt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Shifts as multiplication / floor division by powers of two.
    function automatic void ref_shift(input logic [1:0] op, input logic [31:0] a, input int sh,
                                      output logic [31:0] r, output bit e);
        longint unsigned ua, pw, p;
        longint sv;
        ua = longint'(a);
        pw = longint'(1) << sh;
        r  = '0;
        e  = 1'b0;
        case (op)
            2'b00: begin p = ua * pw; r = p[31:0]; end
            2'b01: begin p = ua / pw; r = p[31:0]; end
            2'b10: begin
`ifdef SHIFT_ARBITER_SRA_EN
                sv = longint'($signed(a));
                if (sv < 0) sv = (sv - longint'(pw - 1)) / longint'(pw);
                else        sv = sv / longint'(pw);
                r = sv[31:0];
`else
                e = 1'b1;
`endif
            end
            default: e = 1'b1;
        endcase
    endfunction

    // One clock cycle: drive, check readys, advance the model, check the response slot.
    task automatic cycle(input bit r,
                         input bit v0, input logic [1:0] o0, input logic [31:0] i0,
                         input logic [4:0] s0,
                         input bit v1, input logic [1:0] o1, input logic [31:0] i1,
                         input logic [4:0] s1,
                         input bit rr);
        bit free, e0, e1, g0, g1, e;
        logic [31:0] d;
        rst = r;
        req0_valid = v0; req0_op = o0; req0_in = i0; req0_shamt = s0;
        req1_valid = v1; req1_op = o1; req1_in = i1; req1_shamt = s1;
        rsp_ready = rr;
        #1;
        free = !m_full || rr;
        e0 = !r && free && (!m_prio || !v1);
        e1 = !r && free && ( m_prio || !v0);
        check_eq("req0_ready", req0_ready, e0);
        check_eq("req1_ready", req1_ready, e1);
        g0 = v0 && e0;
        g1 = v1 && e1;
        last_g0 = g0;
        last_g1 = g1;
        @(posedge clk);
        #1;
        if (r) begin
            m_full = 0; m_data = '0; m_id = 0; m_err = 0; m_prio = 0;
        end else if (g0 || g1) begin
            if (g1) ref_shift(o1, i1, int'(s1), d, e);
            else    ref_shift(o0, i0, int'(s0), d, e);
            m_full = 1; m_data = d; m_err = e; m_id = g1; m_prio = !g1;
        end else if (rr) begin
            m_full = 0;
        end
        check_eq("rsp_valid", rsp_valid, m_full);
        if (m_full || r) begin
            check_eq("rsp_data", rsp_data, m_data);
            check_eq("rsp_id", rsp_id, m_id);
            check_eq("rsp_err", rsp_err, m_err);
        end
    endtask

    task automatic do_reset();
        cycle(1, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1);
    endtask

    initial begin
        bit          v0, v1, r, r_prev;
        logic [1:0]  o0, o1;
        logic [31:0] i0, i1;
        logic [4:0]  s0, s1;

        m_full = 0; m_data = '0; m_id = 0; m_err = 0; m_prio = 0;
        do_reset();
        do_reset();
        check_eq("reset_valid", rsp_valid, 1'b0);
        check_eq("reset_data", rsp_data, 32'h0);

        // SRL of the MSB all the way down
        cycle(0, 1, SHIFT_SRL, 32'h8000_0000, 31, 0, SHIFT_SLL, 0, 0, 1);
        check_eq("srl31_valid", rsp_valid, 1'b1);
        check_eq("srl31_data", rsp_data, 32'h0000_0001);
        check_eq("srl31_id", rsp_id, 1'b0);
        check_eq("srl31_err", rsp_err, 1'b0);

        // Reserved opcode from requester 1, then SLL by zero
        cycle(0, 0, SHIFT_SLL, 0, 0, 1, SHIFT_RSVD, 32'hDEAD_BEEF, 3, 1);
        check_eq("rsvd_data", rsp_data, 32'h0);
        check_eq("rsvd_err", rsp_err, 1'b1);
        check_eq("rsvd_id", rsp_id, 1'b1);
        cycle(0, 1, SHIFT_SLL, 32'h1, 0, 0, SHIFT_SLL, 0, 0, 1);
        check_eq("sll0_data", rsp_data, 32'h0000_0001);

        cycle(0, 1, SHIFT_SRA, 32'h8000_0000, 4, 0, SHIFT_SLL, 0, 0, 1);
`ifdef SHIFT_ARBITER_SRA_EN
        check_eq("sra_data", rsp_data, 32'hF800_0000);
        check_eq("sra_err", rsp_err, 1'b0);
`else
        check_eq("sra_data", rsp_data, 32'h0);
        check_eq("sra_err", rsp_err, 1'b1);
`endif

        // Both requesters always valid: grants alternate starting with 0
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cycle(0, 1, SHIFT_SLL, 32'h3, 1, 1, SHIFT_SRL, 32'hC0, 2, 1);
            check_eq("alt_valid", rsp_valid, 1'b1);
            check_eq("alt_id", rsp_id, k[0]);
            check_eq("alt_data", rsp_data, k[0] ? 32'h30 : 32'h6);
        end

        // Back-pressure: slot holds for 5 cycles, then the pending req1 goes straight in
        do_reset();
        cycle(0, 1, SHIFT_SLL, 32'h1, 4, 1, SHIFT_SRL, 32'h100, 4, 1);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1, SHIFT_SLL, 32'h7, 1, 1, SHIFT_SRL, 32'h100, 4, 0);
            check_eq("hold_data", rsp_data, 32'h10);
            check_eq("hold_id", rsp_id, 1'b0);
        end
        cycle(0, 1, SHIFT_SLL, 32'h7, 1, 1, SHIFT_SRL, 32'h100, 4, 1);
        check_eq("release_id", rsp_id, 1'b1);
        check_eq("release_data", rsp_data, 32'h10);

        // Reset while FULL discards the result and restores priority to requester 0
        cycle(0, 1, SHIFT_SLL, 32'h7, 1, 0, SHIFT_SLL, 0, 0, 0);
        cycle(1, 1, SHIFT_SLL, 32'h7, 1, 1, SHIFT_SLL, 32'h9, 1, 0);
        check_eq("rst_full_valid", rsp_valid, 1'b0);
        cycle(0, 1, SHIFT_SLL, 32'h7, 1, 1, SHIFT_SLL, 32'h9, 1, 1);
        check_eq("post_rst_id", rsp_id, 1'b0);
        check_eq("post_rst_data", rsp_data, 32'hE);

        // Randomized traffic; a refused request is held stable until accepted
        do_reset();
        v0 = 0; v1 = 0; r_prev = 1;
        o0 = 0; o1 = 0; i0 = 0; i1 = 0; s0 = 0; s1 = 0;
        for (int k = 0; k < 600; k++) begin
            r = ($urandom_range(0, 59) == 0);
            if (!(v0 && !last_g0 && !r_prev)) begin
                v0 = ($urandom_range(0, 3) != 0);
                o0 = 2'($urandom_range(0, 3));
                i0 = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
                s0 = 5'($urandom_range(0, 31));
            end
            if (!(v1 && !last_g1 && !r_prev)) begin
                v1 = ($urandom_range(0, 3) != 0);
                o1 = 2'($urandom_range(0, 3));
                i1 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_0F0F : $urandom;
                s1 = 5'($urandom_range(0, 31));
            end
            cycle(r, v0, o0, i0, s0, v1, o1, i1, s1, ($urandom_range(0, 3) != 0));
            r_prev = r;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
